// File: rtl/piso_transmitter.sv
// Parallel-in serial-out frame transmitter: start bit 0, WIDTH data bits LSB
// first, stop bit 1, each bit held CLKS_PER_BIT clocks on a registered line.
module piso_transmitter #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             Q,
  output logic             busy,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] shifted;
  logic             q_q, q_d;
  logic             done_q, done_d;
  logic             bitEnd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      q_q     <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  // The line is computed one cycle ahead so Q comes straight from a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    q_d     = q_q;
    done_d  = 1'b0;
    shifted = shift_q >> 1;
    bitEnd  = (cnt_q == CW'(CLKS_PER_BIT - 1));

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        q_d   = 1'b1;
        if (load_valid) begin
          shift_d = data_in;
          state_d = START;
          q_d     = 1'b0;
        end
      end
      START: begin
        if (bitEnd) begin
          cnt_d   = '0;
          state_d = DATA;
          q_d     = shift_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (bitEnd) begin
          cnt_d = '0;
          if (bit_q == BW'(WIDTH - 1)) begin
            bit_d   = '0;
            state_d = STOP;
            q_d     = 1'b1;
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shifted;
            q_d     = shifted[0];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        q_d = 1'b1;
        if (bitEnd) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        q_d     = 1'b1;
      end
    endcase
  end

  assign load_ready = (state_q == IDLE) && !rst;
  assign busy       = (state_q != IDLE);
  assign Q          = q_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_transmitter.sv
// Self-checking bench: two transmitters (1 and 3 clocks per bit) compared
// against a frame model that derives each line bit from its position in the frame.
module tb_piso_transmitter;

  logic       clk;
  logic       rst;
  logic [3:0] dataIn;
  logic       lv;
  logic       sel;
  logic       lv0, lv3;
  logic       ready0, q0, busy0, done0;
  logic       ready3, q3, busy3, done3;
  logic       obsReady, obsQ, obsBusy, obsDone;
  int         total;
  int         bad;

  assign lv0      = sel ? 1'b0 : lv;
  assign lv3      = sel ? lv : 1'b0;
  assign obsReady = sel ? ready3 : ready0;
  assign obsQ     = sel ? q3 : q0;
  assign obsBusy  = sel ? busy3 : busy0;
  assign obsDone  = sel ? done3 : done0;

  piso_transmitter #(.WIDTH(4), .CLKS_PER_BIT(1)) dutFast (
    .clk(clk), .rst(rst), .data_in(dataIn), .load_valid(lv0),
    .load_ready(ready0), .Q(q0), .busy(busy0), .done(done0)
  );

  piso_transmitter #(.WIDTH(4), .CLKS_PER_BIT(3)) dutSlow (
    .clk(clk), .rst(rst), .data_in(dataIn), .load_valid(lv3),
    .load_ready(ready3), .Q(q3), .busy(busy3), .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line level expected c cycles after the handshake edge (c = 0 is the first frame cycle).
  function automatic logic expBit(input logic [3:0] w, input int c, input int cpb);
    int b;
    b = c / cpb;
    if (b == 0) return 1'b0;
    if (b <= 4) return w[b-1];
    return 1'b1;
  endfunction

  task automatic runFrame(input bit slow, input logic [3:0] word, input bit noisy, input string tag);
    int cpb;
    int len;
    cpb = slow ? 3 : 1;
    len = 6 * cpb;
    @(negedge clk);
    sel = slow;
    dataIn = word;
    lv = 1'b1;
    total++;
    if (obsReady !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s ready_before_load got=%b want=1", tag, obsReady);
    end
    @(posedge clk);
    #1;
    lv = 1'b0;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      total++;
      if (obsQ !== expBit(word, c, cpb)) begin
        bad++;
        $display("[TB] FAIL %s q cycle=%0d got=%b want=%b", tag, c, obsQ, expBit(word, c, cpb));
      end
      total++;
      if (obsBusy !== 1'b1 || obsDone !== 1'b0 || obsReady !== 1'b0) begin
        bad++;
        $display("[TB] FAIL %s flags cycle=%0d got busy=%b done=%b ready=%b want busy=1 done=0 ready=0",
                 tag, c, obsBusy, obsDone, obsReady);
      end
      if (noisy) begin
        dataIn = 4'($urandom);
        lv = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    lv = 1'b0;
    total++;
    if (obsDone !== 1'b1 || obsBusy !== 1'b0 || obsReady !== 1'b1 || obsQ !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s end got done=%b busy=%b ready=%b q=%b want done=1 busy=0 ready=1 q=1",
               tag, obsDone, obsBusy, obsReady, obsQ);
    end
  endtask

  task automatic test_reset;
    #1;
    total++;
    if (obsQ !== 1'b1 || obsBusy !== 1'b0 || obsReady !== 1'b0 || obsDone !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state got q=%b busy=%b ready=%b done=%b want q=1 busy=0 ready=0 done=0",
               obsQ, obsBusy, obsReady, obsDone);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (ready0 !== 1'b1 || ready3 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_release_ready got fast=%b slow=%b want 1", ready0, ready3);
    end
  endtask

  task automatic test_idle;
    sel = 1'b0;
    lv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (obsQ !== 1'b1 || obsDone !== 1'b0 || obsReady !== 1'b1 || obsBusy !== 1'b0) begin
        bad++;
        $display("[TB] FAIL idle cycle=%0d got q=%b done=%b ready=%b busy=%b want q=1 done=0 ready=1 busy=0",
                 i, obsQ, obsDone, obsReady, obsBusy);
      end
    end
  endtask

  task automatic test_basic;
    runFrame(1'b0, 4'b1011, 1'b0, "basic_1011");
  endtask

  task automatic test_slow;
    runFrame(1'b1, 4'b0100, 1'b0, "slow_0100");
  endtask

  task automatic test_back_to_back;
    logic [3:0] w1;
    logic [3:0] w2;
    w1 = 4'b1111;
    w2 = 4'b0000;
    @(negedge clk);
    sel = 1'b0;
    dataIn = w1;
    lv = 1'b1;
    @(posedge clk);
    #1;
    dataIn = w2;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (obsQ !== expBit(w1, c, 1) || obsBusy !== 1'b1) begin
        bad++;
        $display("[TB] FAIL b2b_first cycle=%0d got q=%b busy=%b want q=%b busy=1",
                 c, obsQ, obsBusy, expBit(w1, c, 1));
      end
    end
    @(negedge clk);
    total++;
    if (obsDone !== 1'b1 || obsReady !== 1'b1) begin
      bad++;
      $display("[TB] FAIL b2b_gap got done=%b ready=%b want done=1 ready=1", obsDone, obsReady);
    end
    @(posedge clk);
    #1;
    lv = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (obsQ !== expBit(w2, c, 1) || obsBusy !== 1'b1 || obsDone !== 1'b0) begin
        bad++;
        $display("[TB] FAIL b2b_second cycle=%0d got q=%b busy=%b done=%b want q=%b busy=1 done=0",
                 c, obsQ, obsBusy, obsDone, expBit(w2, c, 1));
      end
    end
    @(negedge clk);
    total++;
    if (obsDone !== 1'b1 || obsBusy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_end got done=%b busy=%b want done=1 busy=0", obsDone, obsBusy);
    end
  endtask

  task automatic test_ignore_midframe;
    for (int i = 0; i < 4; i++)
      runFrame(1'($urandom_range(0, 1)), 4'($urandom), 1'b1, "noisy");
  endtask

  task automatic test_reset_midframe;
    logic [3:0] w;
    w = 4'($urandom);
    @(negedge clk);
    sel = 1'b0;
    dataIn = w;
    lv = 1'b1;
    @(posedge clk);
    #1;
    lv = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (obsQ !== expBit(w, 2, 1) || obsBusy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_pre got q=%b busy=%b want q=%b busy=1", obsQ, obsBusy, expBit(w, 2, 1));
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (obsQ !== 1'b1 || obsBusy !== 1'b0 || obsReady !== 1'b0 || obsDone !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_async got q=%b busy=%b ready=%b done=%b want q=1 busy=0 ready=0 done=0",
               obsQ, obsBusy, obsReady, obsDone);
    end
    lv = 1'b1;
    dataIn = 4'b0110;
    @(posedge clk);
    #1;
    total++;
    if (obsBusy !== 1'b0 || obsQ !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_no_handshake got busy=%b q=%b want busy=0 q=1", obsBusy, obsQ);
    end
    @(negedge clk);
    lv = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (obsReady !== 1'b1 || obsDone !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_release got ready=%b done=%b want ready=1 done=0", obsReady, obsDone);
    end
    @(negedge clk);
    total++;
    if (obsDone !== 1'b0 || obsBusy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_no_done got done=%b busy=%b want done=0 busy=0", obsDone, obsBusy);
    end
    runFrame(1'b0, 4'b1001, 1'b0, "after_rst_1001");
  endtask

  task automatic test_random;
    for (int i = 0; i < 10; i++)
      runFrame(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), "random");
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    lv = 1'b0;
    sel = 1'b0;
    dataIn = 4'b0000;
    test_reset();
    test_idle();
    test_basic();
    test_slow();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_transmitter.md
PISO_TRANSMITTER -- requirements
Module: piso_transmitter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the number of data bits per frame (legal range 1..32).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 1, setting the clock cycles per serial bit (legal range 1..65535).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port data_in, input, WIDTH bits: parallel word to transmit.
REQ-006 The block SHALL have port load_valid, input, 1 bit: data_in is valid.
REQ-007 The block SHALL have port load_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 The block SHALL have port Q, output, 1 bit: registered serial line output, idle level 1.
REQ-009 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse at frame completion.

Function
REQ-011 States SHALL be IDLE, START, DATA, STOP; encoding is free.
REQ-012 A frame SHALL be: start bit 0, then WIDTH data bits LSB first, then stop bit 1; each bit held exactly CLKS_PER_BIT cycles; frame length (WIDTH+2)*CLKS_PER_BIT cycles.
REQ-013 load_ready SHALL be 1 only in IDLE with rst low; it SHALL be a function of state only, never of load_valid.
REQ-014 A handshake SHALL occur on a rising edge where load_valid and load_ready are both 1; data_in SHALL be captured into an internal shift register on that edge and the state SHALL move to START.
REQ-015 Q SHALL show the start bit in the cycle directly after the handshake edge (latency 1 cycle), with no glitch.
REQ-016 In START, after CLKS_PER_BIT cycles the state SHALL move to DATA with Q = captured bit 0.
REQ-017 In DATA, every CLKS_PER_BIT cycles the shift register SHALL shift right by one and Q SHALL take the next bit; a bit counter of ceil(log2(WIDTH+1)) bits SHALL count sent bits; after bit WIDTH-1 completes the state SHALL move to STOP.
REQ-018 In STOP, Q SHALL be 1 for CLKS_PER_BIT cycles, then the state SHALL return to IDLE.
REQ-019 done SHALL be 1 for exactly one cycle, the first IDLE cycle after STOP; load_ready is also 1 in that cycle, so back-to-back frames SHALL have no idle gap beyond that one cycle.
REQ-020 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-021 load_valid and data_in changes SHALL be ignored while busy; the captured word SHALL NOT change mid-frame.
REQ-022 In IDLE without a handshake, Q SHALL stay 1 and all counters SHALL hold 0.
REQ-023 The bit-period counter SHALL reset to 0 at each bit boundary; with CLKS_PER_BIT=1 every state/bit lasts one cycle.

Reset
REQ-024 While rst is 1, the block SHALL force: state IDLE, Q=1, busy=0, done=0, load_ready=0, counters 0, shift register 0; this takes effect immediately, independent of clk.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no done pulse; load_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-026 A handshake SHALL NOT be accepted on the edge where rst is high.

Verification (WIDTH=4 unless stated)
REQ-027 The bench SHALL check: CLKS_PER_BIT=1, load 4'b1011 -> Q = 0,1,1,0,1,1 on successive cycles, busy high for 6 cycles, done pulses once on cycle 7.
REQ-028 The bench SHALL check: CLKS_PER_BIT=3, load 4'b0100 -> each Q bit held 3 cycles (0 x3, 0,0,1,0 each x3, 1 x3), 18 busy cycles.
REQ-029 The bench SHALL check: load_valid held high with 4'b1111 then 4'b0000 -> second start bit begins the cycle after done, no extra idle cycle.
REQ-030 The bench SHALL check: data_in toggled and load_valid pulsed during a frame -> transmitted bits match the originally captured word, load_ready stays 0.
REQ-031 The bench SHALL check: rst pulsed during the DATA state -> Q=1 and busy=0 asynchronously, no done pulse, next load 4'b1001 sends 0,1,0,0,1,1.
REQ-032 The bench SHALL check: no load_valid for 20 cycles after reset -> Q stays 1, done never asserts, load_ready stays 1.
